// File: rtl/riego_pkg.sv
// Shared types, threshold table and BCD helper for the irrigation controller.
package riego_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    EVALUA = 2'd1,
    RIEGO  = 2'd2,
    ESPERA = 2'd3
  } estado_t;

  localparam int HUM_MAX = 100;

  // Humidity threshold in percent, indexed by plant type.
  localparam logic [6:0] UMBRAL_TAB [8] = '{7'd20, 7'd30, 7'd40, 7'd50,
                                            7'd60, 7'd70, 7'd35, 7'd25};

  // Three BCD digits to binary; only meaningful when every digit is <= 9.
  function automatic logic [9:0] bcd3_a_bin(input logic [11:0] bcd);
    return (10'(bcd[11:8]) * 10'd100) + (10'(bcd[7:4]) * 10'd10) + 10'(bcd[3:0]);
  endfunction

  function automatic logic [6:0] umbral_de(input logic [2:0] idx);
    return UMBRAL_TAB[idx];
  endfunction

endpackage

// File: rtl/control_riego_if.sv
// Frame inputs from the serial decoder and pump/status outputs of the controller.
interface control_riego_if;
  logic        listo;
  logic [11:0] humedad;
  logic [15:0] hora;
  logic [3:0]  tipoPlanta;
  logic        bomba;
  logic [6:0]  umbral;
  logic [6:0]  humedad_bin;
  logic        error_dato;
  logic [1:0]  estado;

  // Decoder / system side.
  modport master (
    output listo, humedad, hora, tipoPlanta,
    input  bomba, umbral, humedad_bin, error_dato, estado
  );

  // Controller side.
  modport slave (
    input  listo, humedad, hora, tipoPlanta,
    output bomba, umbral, humedad_bin, error_dato, estado
  );
endinterface

// File: rtl/tick_seg.sv
// Free-running one-second tick generator; clr restarts a full second.
module tick_seg #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..TICK_DIV-1 and wrap; clear takes priority so a restarted second is whole.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);
endmodule

// File: rtl/control_riego.sv
// Irrigation controller: validates decoder frames, looks up the plant threshold
// and runs a timed watering plus soak period inside the allowed hour window.
// Optional build macro CORTE_HUMEDAD_EN: a wet-enough frame during watering
// ends the pump phase early.
//
//   state  | meaning
//   REPOSO | idle, waiting for a pending valid frame
//   EVALUA | one-cycle decision: water or return to idle
//   RIEGO  | pump on, counting down RIEGO_SEG seconds
//   ESPERA | pump off, soak countdown of ESPERA_SEG seconds
module control_riego
  import riego_pkg::*;
#(
  parameter int          TICK_DIV   = 50000000,
  parameter int          RIEGO_SEG  = 10,
  parameter int          ESPERA_SEG = 30,
  parameter logic [15:0] HORA_INI   = 16'h0600,
  parameter logic [15:0] HORA_FIN   = 16'h1900
) (
  input logic            clk,
  input logic            rst,
  control_riego_if.slave bus
);

  logic sync1, sync2, sync3;
  logic strobe;

  logic       nib_ok;
  logic [9:0] hum_bin10;
  logic [7:0] hh, mm;
  logic       frame_ok;
  logic       frame_valid;
  logic [6:0] hum_new;
  logic [6:0] umb_new;
  logic       corte;

  logic [6:0]  humedad_bin_q;
  logic [6:0]  umbral_q;
  logic        error_q;
  logic [15:0] hora_q;
  logic        pending;
  logic        en_ventana;

  estado_t    state_q, state_d;
  logic [7:0] seg_q, seg_d;
  logic       clr_tick;
  logic       tick;
  logic       bomba_q;

  // listo comes from another clock domain: two flops, then a third for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.listo;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign strobe = sync2 & ~sync3;

  assign nib_ok = (bus.humedad[11:8] <= 4'd9) && (bus.humedad[7:4] <= 4'd9) &&
                  (bus.humedad[3:0]  <= 4'd9) &&
                  (bus.hora[15:12]   <= 4'd9) && (bus.hora[11:8] <= 4'd9) &&
                  (bus.hora[7:4]     <= 4'd9) && (bus.hora[3:0]  <= 4'd9);

  assign hum_bin10 = bcd3_a_bin(bus.humedad);
  assign hh        = (8'(bus.hora[15:12]) * 8'd10) + 8'(bus.hora[11:8]);
  assign mm        = (8'(bus.hora[7:4])   * 8'd10) + 8'(bus.hora[3:0]);

  assign frame_ok = nib_ok && (hum_bin10 <= 10'(HUM_MAX)) && (hh <= 8'd23) &&
                    (mm <= 8'd59) && (bus.tipoPlanta <= 4'd7);

  assign frame_valid = strobe && frame_ok;
  assign hum_new     = hum_bin10[6:0];
  assign umb_new     = umbral_de(bus.tipoPlanta[2:0]);

`ifdef CORTE_HUMEDAD_EN
  assign corte = frame_valid && (state_q == RIEGO) &&
                 ({1'b0, hum_new} >= ({1'b0, umb_new} + 8'd10));
`else
  assign corte = 1'b0;
`endif

  // Latch frame data on the strobe; invalid frames only raise the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      humedad_bin_q <= '0;
      umbral_q      <= '0;
      hora_q        <= '0;
      error_q       <= 1'b0;
    end else if (strobe) begin
      if (frame_ok) begin
        humedad_bin_q <= hum_new;
        umbral_q      <= umb_new;
        hora_q        <= bus.hora;
        error_q       <= 1'b0;
      end else begin
        error_q <= 1'b1;
      end
    end
  end

  // A new valid frame wins over the clear done when idle picks up the pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (frame_valid && !corte) begin
      pending <= 1'b1;
    end else if (state_q == REPOSO) begin
      pending <= 1'b0;
    end
  end

  // Plain 16-bit compare is ordered correctly for valid BCD hhmm.
  assign en_ventana = (hora_q >= HORA_INI) && (hora_q < HORA_FIN);

  tick_seg #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_tick),
    .tick (tick)
  );

  // Next-state, seconds countdown and tick restart on entry to a timed state.
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    clr_tick = 1'b0;
    case (state_q)
      REPOSO: begin
        if (pending) state_d = EVALUA;
      end
      EVALUA: begin
        if ((humedad_bin_q < umbral_q) && en_ventana) begin
          state_d  = RIEGO;
          seg_d    = 8'(RIEGO_SEG);
          clr_tick = 1'b1;
        end else begin
          state_d = REPOSO;
        end
      end
      RIEGO: begin
        if (corte) begin
          state_d  = ESPERA;
          seg_d    = 8'(ESPERA_SEG);
          clr_tick = 1'b1;
        end else if (tick) begin
          if (seg_q == 8'd1) begin
            state_d  = ESPERA;
            seg_d    = 8'(ESPERA_SEG);
            clr_tick = 1'b1;
          end else begin
            seg_d = seg_q - 8'd1;
          end
        end
      end
      ESPERA: begin
        if (tick) begin
          if (seg_q == 8'd1) begin
            state_d = REPOSO;
            seg_d   = '0;
          end else begin
            seg_d = seg_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = REPOSO;
        seg_d   = '0;
      end
    endcase
  end

  // State, countdown and pump register; pump is decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REPOSO;
      seg_q   <= '0;
      bomba_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      bomba_q <= (state_d == RIEGO);
    end
  end

  assign bus.bomba       = bomba_q;
  assign bus.umbral      = umbral_q;
  assign bus.humedad_bin = humedad_bin_q;
  assign bus.error_dato  = error_q;
  assign bus.estado      = state_q;

endmodule

// File: tb/tb_control_riego.sv
// Scoreboard bench for control_riego: stimulus pushes expected evaluations,
// a monitor pops them whenever the controller enters its decision state.
module tb_control_riego;
  localparam int TD = 4;
  localparam int RS = 3;
  localparam int ES = 2;
  localparam int ST_REPOSO = 0, ST_EVALUA = 1, ST_RIEGO = 2, ST_ESPERA = 3;

  typedef struct {
    int hb;
    int um;
    bit water;
  } eval_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_riego_if bus();

  control_riego #(.TICK_DIV(TD), .RIEGO_SEG(RS), .ESPERA_SEG(ES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  eval_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit mon_off = 1'b1;
  bit corte_flag = 1'b0;
  bit pend_q = 1'b0;
  int m_hb = 0, m_um = 0;
  bit m_err = 1'b0;
  int thr[8] = '{20, 30, 40, 50, 60, 70, 35, 25};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dig(input int v, input int i);
    return (v >> (4 * i)) & 15;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic bit model_valid(input int h, input int hr, input int t);
    for (int i = 0; i < 3; i++) if (dig(h, i) > 9) return 1'b0;
    for (int i = 0; i < 4; i++) if (dig(hr, i) > 9) return 1'b0;
    if (dig(h, 2) * 100 + dig(h, 1) * 10 + dig(h, 0) > 100) return 1'b0;
    if (dig(hr, 3) * 10 + dig(hr, 2) > 23) return 1'b0;
    if (dig(hr, 1) * 10 + dig(hr, 0) > 59) return 1'b0;
    return (t <= 7);
  endfunction

  // Drive one frame; ocupado means the controller is currently watering.
  task automatic send_frame(input int h, input int hr, input int t, input bit ocupado);
    bit v;
    bit cut;
    eval_t e;
    v = model_valid(h, hr, t);
    cut = 1'b0;
    if (v) begin
      m_hb = dig(h, 2) * 100 + dig(h, 1) * 10 + dig(h, 0);
      m_um = thr[t];
      m_err = 1'b0;
      e.hb = m_hb;
      e.um = m_um;
      e.water = (m_hb < m_um) && (hr >= 'h0600) && (hr < 'h1900);
`ifdef CORTE_HUMEDAD_EN
      if (ocupado && (m_hb >= m_um + 10)) cut = 1'b1;
`endif
      if (cut) begin
        corte_flag = 1'b1;
      end else if (!ocupado) begin
        q.push_back(e);
      end else if (pend_q) begin
        q[q.size() - 1] = e;
      end else begin
        q.push_back(e);
        pend_q = 1'b1;
      end
    end else begin
      m_err = 1'b1;
    end
    bus.humedad = h[11:0];
    bus.hora = hr[15:0];
    bus.tipoPlanta = t[3:0];
    bus.listo = 1'b1;
    repeat (3) @(negedge clk);
    chk("error_dato", bus.error_dato, m_err);
    chk("humedad_bin", bus.humedad_bin, m_hb);
    chk("umbral", bus.umbral, m_um);
    @(negedge clk);
    if (!ocupado) chk("estado_latency", bus.estado, v ? ST_EVALUA : ST_REPOSO);
    if (cut) chk("estado_corte", bus.estado, ST_ESPERA);
    bus.listo = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle();
    int stable;
    stable = 0;
    for (int i = 0; i < 200 && stable < 4; i++) begin
      @(negedge clk);
      if (bus.estado == ST_REPOSO && !bus.bomba) stable++;
      else stable = 0;
    end
    chk("idle_reached", (stable >= 4) ? 1 : 0, 1);
    pend_q = 1'b0;
    corte_flag = 1'b0;
  endtask

  // Monitor: pops an expectation on each entry into EVALUA and times the pump/soak phases.
  int cnt_b = 0, cnt_e = 0, prev = 0;
  bit chk_next = 1'b0, exp_water = 1'b0;
  always @(negedge clk) begin
    if (rst || mon_off) begin
      cnt_b = 0;
      cnt_e = 0;
      prev = ST_REPOSO;
      chk_next = 1'b0;
    end else begin
      if (chk_next) begin
        chk("estado_after_eval", bus.estado, exp_water ? ST_RIEGO : ST_REPOSO);
        chk("bomba_after_eval", bus.bomba, exp_water);
        chk_next = 1'b0;
      end
      if (bus.estado == ST_EVALUA && prev != ST_EVALUA) begin
        chk("eval_expected", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          eval_t e;
          e = q.pop_front();
          chk("eval_humedad_bin", bus.humedad_bin, e.hb);
          chk("eval_umbral", bus.umbral, e.um);
          exp_water = e.water;
          chk_next = 1'b1;
        end
      end
      chk("bomba_vs_estado", bus.bomba, (bus.estado == ST_RIEGO) ? 1 : 0);
      if (bus.bomba) begin
        cnt_b++;
      end else if (cnt_b != 0) begin
        if (!corte_flag) chk("pump_cycles", cnt_b, RS * TD);
        cnt_b = 0;
      end
      if (bus.estado == ST_ESPERA) begin
        cnt_e++;
      end else if (cnt_e != 0) begin
        chk("soak_cycles", cnt_e, ES * TD);
        chk("after_soak", bus.estado, ST_REPOSO);
        cnt_e = 0;
      end
      prev = bus.estado;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, hr, t, busy;
    bus.listo = 1'b0;
    bus.humedad = '0;
    bus.hora = '0;
    bus.tipoPlanta = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bomba", bus.bomba, 0);
    chk("rst_estado", bus.estado, ST_REPOSO);
    chk("rst_umbral", bus.umbral, 0);
    chk("rst_humedad_bin", bus.humedad_bin, 0);
    chk("rst_error", bus.error_dato, 0);
    rst = 1'b0;
    mon_off = 1'b0;
    @(negedge clk);

    send_frame('h025, 'h1030, 2, 1'b0); wait_idle();
    send_frame('h055, 'h1030, 2, 1'b0); wait_idle();
    send_frame('h010, 'h2130, 2, 1'b0); wait_idle();
    send_frame('h010, 'h0600, 2, 1'b0); wait_idle();
    send_frame('h010, 'h1900, 2, 1'b0); wait_idle();

    send_frame('h1A0, 'h1030, 2, 1'b0); wait_idle();
    send_frame('h025, 'h2460, 2, 1'b0); wait_idle();
    send_frame('h025, 'h1030, 9, 1'b0); wait_idle();
    send_frame('h055, 'h1030, 0, 1'b0); wait_idle();

    send_frame('h010, 'h1030, 2, 1'b0);
    send_frame('h015, 'h1030, 2, 1'b1);
    send_frame('h030, 'h1030, 2, 1'b1);
    wait_idle();

`ifdef CORTE_HUMEDAD_EN
    send_frame('h010, 'h1030, 2, 1'b0);
    send_frame('h050, 'h1030, 2, 1'b1);
    wait_idle();
`endif

    send_frame('h010, 'h1030, 2, 1'b0);
    send_frame('h015, 'h1030, 2, 1'b1);
    mon_off = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bomba", bus.bomba, 0);
    chk("midrst_estado", bus.estado, ST_REPOSO);
    rst = 1'b0;
    q.delete();
    pend_q = 1'b0;
    m_hb = 0;
    m_um = 0;
    m_err = 1'b0;
    chk("midrst_humedad_bin", bus.humedad_bin, 0);
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.estado != ST_REPOSO) busy++;
    end
    chk("midrst_no_pending", busy, 0);
    mon_off = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      h = to_bcd($urandom_range(0, 110));
      if ($urandom_range(0, 9) == 0) h = (h & 'hFF0) | $urandom_range(10, 15);
      hr = (to_bcd($urandom_range(0, 25)) << 8) | to_bcd($urandom_range(0, 61));
      t = $urandom_range(0, 8);
      send_frame(h, hr, t, 1'b0);
      wait_idle();
    end

    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
